// File: rtl/karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl
//
// Sequential Karatsuba multiplier. It computes a full WIDTH x WIDTH unsigned
// product by running one (WIDTH/2+1)-bit multiplier three times, once for
// each partial product, and then recombining the three results.
//
// Ports
//   iClk    in   1          clock, rising edge
//   iRst    in   1          asynchronous active-high reset
//   iStart  in   1          start request, taken only while oBusy=0
//   iX      in   WIDTH      multiplicand, sampled on the accepting edge
//   iY      in   WIDTH      multiplier, sampled on the accepting edge
//   oBusy   out  1          high while an operation is in progress
//   oDone   out  1          one-cycle pulse when oO has just been updated
//   oO      out  2*WIDTH    registered product, held until the next oDone
//   oState  out  3          current controller state (debug visibility)
//
// Handshake: a start is accepted on any rising edge where iStart=1 and
// oBusy=0. No back-pressure exists. iStart while busy is dropped without
// effect. oDone marks the single cycle in which the new oO first appears,
// and oBusy is already low in that cycle, so a new start can be accepted on
// the following edge (one product every 5 cycles).
// ---------------------------------------------------------------------------

// Plain combinational unsigned multiplier that is shared by the controller.
module multiply #(
    parameter int W = 5
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    assign p = a * b;
endmodule

module karatsuba_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [WIDTH-1:0]   iX,
    input  logic [WIDTH-1:0]   iY,
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oO,
    output logic [2:0]         oState
);
    localparam int H = WIDTH / 2;
    localparam int P = 2 * WIDTH + 1;   // recombination width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M2   = 3'd2,
        M1   = 3'd3,
        COMB = 3'd4
    } state_t;

    state_t state, state_next;

    // Latched operands and operand-half sums.
    logic [WIDTH-1:0]   x_q, y_q;
    logic [H:0]         sx_q, sy_q;

    // Partial products.
    logic [2*H-1:0]     z0_q, z2_q;
    logic [2*H+1:0]     zm_q;

    logic [2*WIDTH-1:0] o_q;
    logic               done_q;

    // Shared multiplier.
    logic [H:0]         mul_a, mul_b;
    logic [2*H+1:0]     mul_p;

    multiply #(.W(H + 1)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Sums of operand halves, formed from the live inputs so they can be
    // captured on the same edge as the operands themselves.
    logic [H:0] sx_in, sy_in;
    assign sx_in = {1'b0, iX[WIDTH-1:H]} + {1'b0, iX[H-1:0]};
    assign sy_in = {1'b0, iY[WIDTH-1:H]} + {1'b0, iY[H-1:0]};

    // Next state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iStart) state_next = M0;
            M0:      state_next = M2;
            M2:      state_next = M1;
            M1:      state_next = COMB;
            COMB:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiplier input mux, selected purely by state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            M0: begin
                mul_a = {1'b0, x_q[H-1:0]};
                mul_b = {1'b0, y_q[H-1:0]};
            end
            M2: begin
                mul_a = {1'b0, x_q[WIDTH-1:H]};
                mul_b = {1'b0, y_q[WIDTH-1:H]};
            end
            M1: begin
                mul_a = sx_q;
                mul_b = sy_q;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // Recombination: Z2<<2H + (Zm-Z2-Z0)<<H + Z0, one bit wider than the
    // product. The middle term can never go negative, and the final sum
    // fits in 2*WIDTH bits, so the top bit is simply dropped.
    logic [P-1:0] z0_e, z2_e, zm_e, mid, sum;
    logic         unused_sum_msb;

    always_comb begin
        z0_e = {{(P - 2*H){1'b0}}, z0_q};
        z2_e = {{(P - 2*H){1'b0}}, z2_q};
        zm_e = {{(P - 2*H - 2){1'b0}}, zm_q};
        mid  = zm_e - z2_e - z0_e;
        sum  = (z2_e << (2*H)) + (mid << H) + z0_e;
    end
    assign unused_sum_msb = sum[P-1];

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= state_next;
    end

    // Datapath registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            x_q    <= '0;
            y_q    <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            z0_q   <= '0;
            z2_q   <= '0;
            zm_q   <= '0;
            o_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        x_q  <= iX;
                        y_q  <= iY;
                        sx_q <= sx_in;
                        sy_q <= sy_in;
                    end
                end
                M0:   z0_q <= mul_p[2*H-1:0];
                M2:   z2_q <= mul_p[2*H-1:0];
                M1:   zm_q <= mul_p;
                COMB: begin
                    o_q    <= sum[2*WIDTH-1:0];
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign oBusy  = (state != IDLE);
    assign oDone  = done_q;
    assign oO     = o_q;
    assign oState = state;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: one 8-bit and one 4-bit instance, checked
// against plain integer multiplication and the cycle timing of the block.
module tb_karatsuba_seq_ctrl;

  logic clk;
  logic rst;

  logic        start8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] o8;
  logic [2:0]  st8;

  logic        start4, busy4, done4;
  logic [3:0]  x4, y4;
  logic [7:0]  o4;
  logic [2:0]  st4;

  int total;
  int bad;

  logic [15:0] exp_q[$];

  karatsuba_seq_ctrl #(.WIDTH(8)) dut8 (
    .iClk(clk), .iRst(rst), .iStart(start8), .iX(x8), .iY(y8),
    .oBusy(busy8), .oDone(done8), .oO(o8), .oState(st8)
  );

  karatsuba_seq_ctrl #(.WIDTH(4)) dut4 (
    .iClk(clk), .iRst(rst), .iStart(start4), .iX(x4), .iY(y4),
    .oBusy(busy4), .oDone(done4), .oO(o4), .oState(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Driver: start one 8-bit operation from an idle cycle (#1 after an edge)
  // and follow it until oDone or a cycle budget. Returns with the bench
  // sitting in the oDone cycle. lat=0 means no oDone was seen.
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] got, output int lat, output int busy_n);
    start8 = 1'b1; x8 = x; y8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; got = '0;
    busy_n = busy8 ? 1 : 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; got = o8; break; end
      if (busy8) busy_n++;
    end
  endtask

  task automatic run_op4(input logic [3:0] x, input logic [3:0] y,
                         output logic [7:0] got, output int lat);
    start4 = 1'b1; x4 = x; y4 = y;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; got = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done4) begin lat = n; got = o4; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; x8 = '0; y8 = '0;
    start4 = 1'b0; x4 = '0; y4 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o8 !== 16'h0) begin bad++; $display("FAIL reset_o8: got %h want 0000", o8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8: got %b want 0", done8); end
    total++; if (o4 !== 8'h0) begin bad++; $display("FAIL reset_o4: got %h want 00", o4); end
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++; $display("FAIL reset_flags4: busy=%b done=%b want 0 0", busy4, done4);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One operation with full timing checks.
  task automatic check_op8(input string name, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] got, exp;
    int lat, busy_n;
    exp = 16'(x) * 16'(y);
    run_op8(x, y, got, lat, busy_n);
    total++; if (got !== exp) begin bad++; $display("FAIL %s_product: got %h want %h", name, got, exp); end
    total++; if (lat != 4) begin bad++; $display("FAIL %s_latency: got %0d want 4", name, lat); end
    total++; if (busy_n != 4) begin bad++; $display("FAIL %s_busy_cycles: got %0d want 4", name, busy_n); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL %s_busy_in_done: got %b want 0", name, busy8); end
    @(posedge clk); #1;
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %b want 0", name, done8); end
    total++; if (o8 !== exp) begin bad++; $display("FAIL %s_hold: got %h want %h", name, o8, exp); end
  endtask

  task automatic test_basic();
    check_op8("basic", 8'h5C, 8'hA3);
  endtask

  task automatic test_corners();
    check_op8("ffxff", 8'hFF, 8'hFF);
    check_op8("zero", 8'h00, 8'hB7);
    check_op8("one", 8'h01, 8'hFF);
  endtask

  task automatic test_random();
    logic [15:0] got, e;
    logic [7:0] x, y;
    int lat, busy_n;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      exp_q.push_back(16'(x) * 16'(y));
      run_op8(x, y, got, lat, busy_n);
      e = exp_q.pop_front();
      total++; if (got !== e || lat != 4) begin
        bad++; $display("FAIL random_%0d: %h*%h got %h lat %0d want %h lat 4", i, x, y, got, lat, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic [15:0] e1, e2;
    e1 = 16'(8'h12) * 16'(8'h34);
    e2 = 16'(8'hF0) * 16'(8'h0F);
    ndone = 0;
    start8 = 1'b1; x8 = 8'h12; y8 = 8'h34;
    @(posedge clk); #1;
    x8 = 8'hF0; y8 = 8'h0F;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 5) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          total++; if (n != 4 || o8 !== e1) begin
            bad++; $display("FAIL b2b_first: cycle %0d value %h want cycle 4 value %h", n, o8, e1);
          end
        end else if (ndone == 2) begin
          total++; if (n != 9 || o8 !== e2) begin
            bad++; $display("FAIL b2b_second: cycle %0d value %h want cycle 9 value %h", n, o8, e2);
          end
        end
      end
    end
    total++; if (ndone != 2) begin bad++; $display("FAIL b2b_count: got %0d dones want 2", ndone); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy %b want 0", busy8); end
  endtask

  task automatic test_busy_reject();
    int ndone, dcyc;
    logic [15:0] got, e;
    e = 16'(8'h5C) * 16'(8'hA3);
    ndone = 0; dcyc = 0; got = '0;
    start8 = 1'b1; x8 = 8'h5C; y8 = 8'hA3;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done8) begin ndone++; dcyc = n; got = o8; end
      if (n == 1) begin start8 = 1'b1; x8 = 8'h11; y8 = 8'h11; end
      else begin
        start8 = 1'b0;
        if (n < 4) begin x8 = 8'($urandom); y8 = 8'($urandom); end
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL busy_count: got %0d dones want 1", ndone); end
    total++; if (dcyc != 4 || got !== e) begin
      bad++; $display("FAIL busy_result: cycle %0d value %h want cycle 4 value %h", dcyc, got, e);
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, busy_n;
    logic [15:0] got, e;
    e = 16'(8'h03) * 16'(8'h05);
    start8 = 1'b1; x8 = 8'h5C; y8 = 8'hA3;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;       // now in the second multiply step
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy: got %b want 1", busy8); end
    #2 rst = 1'b1;
    #1;
    total++; if (o8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: o=%h busy=%b done=%b want 0000 0 0", o8, busy8, done8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d dones want 0", ndone); end
    run_op8(8'h03, 8'h05, got, lat, busy_n);
    total++; if (got !== e || lat != 4) begin
      bad++; $display("FAIL rstmid_restart: got %h lat %0d want %h lat 4", got, lat, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4();
    logic [7:0] got, e;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e = 8'(a * b);
        run_op4(4'(a), 4'(b), got, lat);
        total++; if (got !== e || lat != 4) begin
          bad++; $display("FAIL w4_%0d_%0d: got %h lat %0d want %h lat 4", a, b, got, lat, e);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
